// File: rtl/poly_mul_schoolbook.sv
// Schoolbook polynomial multiplier mod q: loads N coefficient pairs, then emits 2N product coefficients.
// One multiply-accumulate term per cycle; the last of the 2N outputs is a zero pad that keeps the stream framed.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef DEGREE_N
`define DEGREE_N 4
`endif

module poly_mul_schoolbook #(
    parameter int WIDTH = `BIT_WIDTH,
    parameter int N     = `DEGREE_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] coeff_o,
    output logic             valid_o
);

    localparam int KW = $clog2(2 * N);
    localparam int IW = $clog2(N);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_MAC  = 1'b1;

    localparam logic [KW-1:0] K_NM1 = KW'(N - 1);
    localparam logic [KW-1:0] K_PAD = KW'(2 * N - 1);
    localparam logic [IW-1:0] B_LAST = IW'(N - 1);

    logic [WIDTH-1:0] mem_a [N];
    logic [WIDTH-1:0] mem_b [N];

    logic [0:0]       state;
    logic [IW-1:0]    beat;
    logic [KW-1:0]    k;
    logic [IW-1:0]    i;
    logic [WIDTH-1:0] acc;

    logic [KW-1:0]      hi_k;
    logic [KW-1:0]      k_nxt;
    logic [KW-1:0]      lo_nxt;
    logic [IW-1:0]      b_idx;
    logic               last_term;
    logic               pad;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_mod;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_next;

    assign ready_o = (state == ST_LOAD);

    // Term window for output k is i in [max(0,k-N+1), min(k,N-1)].
    always_comb begin
        hi_k      = (k > K_NM1) ? K_NM1 : k;
        k_nxt     = k + KW'(1);
        lo_nxt    = (k_nxt > K_NM1) ? (k_nxt - K_NM1) : '0;
        b_idx     = IW'(k - KW'(i));
        last_term = (KW'(i) == hi_k);
        pad       = (k == K_PAD);
        prod      = (2 * WIDTH)'(mem_a[i]) * (2 * WIDTH)'(mem_b[b_idx]);
        prod_mod  = WIDTH'(prod % (2 * WIDTH)'(q));
        sum       = {1'b0, acc} + {1'b0, prod_mod};
        acc_next  = (sum >= {1'b0, q}) ? WIDTH'(sum - {1'b0, q}) : sum[WIDTH-1:0];
    end

    // Operand storage is not reset; a full reload always precedes use.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && valid_i) begin
            mem_a[beat] <= a_i;
            mem_b[beat] <= b_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_LOAD;
            beat    <= '0;
            k       <= '0;
            i       <= '0;
            acc     <= '0;
            valid_o <= 1'b0;
            coeff_o <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (valid_i) begin
                        if (beat == B_LAST) begin
                            beat  <= '0;
                            state <= ST_MAC;
                            k     <= '0;
                            i     <= '0;
                            acc   <= '0;
                        end else begin
                            beat <= beat + IW'(1);
                        end
                    end
                end
                default: begin
                    if (pad) begin
                        coeff_o <= '0;
                        valid_o <= 1'b1;
                        state   <= ST_LOAD;
                        k       <= '0;
                        i       <= '0;
                        acc     <= '0;
                    end else if (last_term) begin
                        coeff_o <= acc_next;
                        valid_o <= 1'b1;
                        acc     <= '0;
                        k       <= k_nxt;
                        i       <= IW'(lo_nxt);
                    end else begin
                        acc <= acc_next;
                        i   <= i + IW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mul_schoolbook.sv
// Scoreboard bench for poly_mul_schoolbook with N=4, q=17: directed operand sets, gapped loads,
// mid-MAC reset and back-to-back products.
module tb_poly_mul_schoolbook;

    localparam int W  = 8;
    localparam int NN = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] q   = 8'd17;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] coeff_o;
    logic         valid_o;

    poly_mul_schoolbook #(.WIDTH(W), .N(NN)) dut (
        .clk     (clk),
        .rst     (rst),
        .q       (q),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .coeff_o (coeff_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_out = 0;
    int out_idx = 0;
    int busy  = 0;
    bit aborted = 1'b0;

    logic [W-1:0] exp_q [$];
    int           first_q [$];

    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] ve [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every output pulse and checks MAC occupancy.
    always @(negedge clk) begin
        logic [W-1:0] e;
        int f;
        if (valid_o === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got coeff=%0d at cycle %0d, expected no output", coeff_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (coeff_o !== e) begin
                    fails++;
                    $display("FAIL coeff[%0d]: got %0d, expected %0d", out_idx, coeff_o, e);
                end
            end
            if (out_idx == 0 && first_q.size() > 0) begin
                f = first_q.pop_front();
                tests++;
                if (cyc != f) begin
                    fails++;
                    $display("FAIL first_valid_latency: got cycle %0d, expected cycle %0d", cyc, f);
                end
            end
            out_idx = (out_idx + 1) % (2 * NN);
            n_out++;
        end
        if (ready_o === 1'b0) begin
            busy++;
        end else begin
            if (busy > 0 && !aborted) begin
                tests++;
                if (busy != NN * NN + 1) begin
                    fails++;
                    $display("FAIL mac_cycles: got %0d, expected %0d", busy, NN * NN + 1);
                end
            end
            busy    = 0;
            aborted = 1'b0;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (ready_o !== 1'b1 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready_o=%b, expected 1 within 200 cycles", ready_o);
        end
    endtask

    // Loads va/vb and queues ve; gap idles a cycle between beats, hold keeps valid_i high through MAC.
    task automatic load(input bit gap, input bit hold);
        int t;
        for (int n = 0; n < 2 * NN; n++) exp_q.push_back(ve[n]);
        for (int j = 0; j < NN; j++) begin
            wait_ready();
            a_i     = va[j];
            b_i     = vb[j];
            valid_i = 1'b1;
            if (j == NN - 1) first_q.push_back(cyc + 2);
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            if (gap && j < NN - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (hold) begin
            t = 0;
            a_i = 8'd15;
            b_i = 8'd15;
            while (ready_o !== 1'b1 && t < 200) begin
                valid_i = 1'b1;
                @(posedge clk);
                #1;
                t++;
            end
            valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        valid_i = 1'b0;
        aborted = 1'b1;
        exp_q.delete();
        first_q.delete();
        out_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_ready_o", int'(ready_o), 1);
        chk("reset_valid_o", int'(valid_o), 0);
        chk("reset_coeff_o", int'(coeff_o), 0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic set_t1();
        va = '{8'd1, 8'd0, 8'd0, 8'd0};
        vb = '{8'd3, 8'd5, 8'd7, 8'd9};
        ve = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    endtask

    task automatic set_t2();
        va = '{8'd1, 8'd1, 8'd0, 8'd0};
        vb = '{8'd0, 8'd0, 8'd0, 8'd1};
        ve = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    endtask

    initial begin
        int base;
        int t;
        do_reset();

        set_t1();
        load(1'b0, 1'b0);
        drain();

        set_t2();
        load(1'b0, 1'b0);
        drain();

        // -1 * -1 terms: every product wraps to 1, sums count the terms.
        va = '{8'd16, 8'd16, 8'd16, 8'd16};
        vb = '{8'd16, 8'd16, 8'd16, 8'd16};
        ve = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        load(1'b0, 1'b0);
        drain();

        // (2+3x)(4+5x) = 8 + 22x + 15x^2, 22 mod 17 = 5.
        va = '{8'd2, 8'd3, 8'd0, 8'd0};
        vb = '{8'd4, 8'd5, 8'd0, 8'd0};
        ve = '{8'd8, 8'd5, 8'd15, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load(1'b1, 1'b1);
        drain();

        set_t1();
        load(1'b1, 1'b1);
        drain();

        // Reset after three outputs of a product.
        set_t1();
        base = n_out;
        load(1'b0, 1'b0);
        t = 0;
        while (n_out < base + 3 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("outputs_before_reset", n_out - base, 3);
        do_reset();
        base = n_out;
        repeat (30) @(posedge clk);
        #1;
        chk("no_output_after_reset", n_out - base, 0);
        set_t1();
        load(1'b0, 1'b0);
        drain();

        // Back-to-back: second load starts in the final-pulse cycle of the first.
        base = n_out;
        set_t1();
        load(1'b0, 1'b0);
        set_t2();
        load(1'b0, 1'b0);
        drain();
        chk("back_to_back_pulses", n_out - base, 4 * NN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/poly_mul_schoolbook.md
POLY_MUL_SCHOOLBOOK -- requirements
Module: poly_mul_schoolbook

Interface
REQ-001 SHALL have parameter WIDTH, default `BIT_WIDTH, coefficient width.
REQ-002 SHALL have parameter N, default `DEGREE_N, polynomial degree (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port q  input  WIDTH  modulus, held stable from first load beat to last output.
REQ-006 SHALL have port a_i  input  WIDTH  operand A coefficient, index ascending per beat, value < q.
REQ-007 SHALL have port b_i  input  WIDTH  operand B coefficient, same index as a_i, value < q.
REQ-008 SHALL have port valid_i  input  1  a_i/b_i beat present.
REQ-009 SHALL have port ready_o  output  1  block accepts beats; a beat transfers when valid_i & ready_o.
REQ-010 SHALL have port coeff_o  output  WIDTH  product coefficient, in [0,q).
REQ-011 SHALL have port valid_o  output  1  coeff_o valid for exactly this cycle; no downstream backpressure.

Function
REQ-012 SHALL have two states: LOAD and MAC.
REQ-013 LOAD: ready_o=1; each transferred beat j (0..N-1) writes a_i to A[j], b_i to B[j]; valid_i with ready_o=0 is ignored.
REQ-014 Nth transfer SHALL move LOAD->MAC on the next edge, with output index k=0, term index i=0, acc=0.
REQ-015 MAC: ready_o=0; one term per cycle, acc_next = (acc + A[i]*B[k-i]) mod q, product 2*WIDTH bits, sum reduced so acc stays in [0,q).
REQ-016 For k, i SHALL range over max(0,k-N+1)..min(k,N-1) ascending; k=0..2N-2 thus take min(k,N-1)-max(0,k-N+1)+1 cycles.
REQ-017 On the last term of k: coeff_o<=acc_next, valid_o<=1 on that edge, acc<=0, k<=k+1, i<=max(0,k+1-N+1).
REQ-018 k=2N-1 (padding) SHALL take exactly one MAC cycle with no term, registering coeff_o=0 and valid_o=1, then state<=LOAD, keeping 2N-coefficient framing for the downstream reducer.
REQ-019 Per product: exactly 2N valid_o pulses, in order k=0..2N-1; MAC occupies N*N+1 cycles.
REQ-020 valid_o for k=0 SHALL assert in the second cycle after the cycle of the Nth transfer.
REQ-021 valid_o SHALL be 0 in every cycle not following a k-completion edge; coeff_o holds its last value when valid_o=0.
REQ-022 ready_o SHALL be 1 in the same cycle as the k=2N-1 valid_o pulse; a new load may begin that cycle.
REQ-023 Back-to-back products SHALL need no idle cycles other than those implied by REQ-013..REQ-022.
REQ-024 Gaps in valid_i during LOAD SHALL only stall loading; beat count persists.

Reset
REQ-025 rst=0 at an edge SHALL set state=LOAD, beat count=0, k=0, i=0, acc=0, valid_o=0, coeff_o=0; ready_o=1 the cycle after.
REQ-026 Reset mid-LOAD or mid-MAC SHALL discard partial operands/results; no valid_o pulse after the reset edge until a new full load.
REQ-027 A/B storage need not be cleared by reset.

Verification (N=4, q=17, WIDTH=`BIT_WIDTH)
REQ-028 A=[1,0,0,0], B=[3,5,7,9] -> coeff_o 3,5,7,9,0,0,0,0; first valid_o 2 cycles after last load beat; 17 MAC cycles.
REQ-029 A=[1,1,0,0], B=[0,0,0,1] -> 0,0,0,1,1,0,0,0.
REQ-030 A=[16,16,16,16], B=[16,16,16,16] -> 1,2,3,4,3,2,1,0 (modular wrap of each term and sum).
REQ-031 Load with valid_i toggling every other cycle, plus valid_i held high during MAC -> same result as contiguous load; MAC-phase beats ignored.
REQ-032 rst=0 during MAC after 3 outputs -> no further valid_o; reload of REQ-028 vectors -> full correct 8-coefficient stream.
REQ-033 Two products back-to-back (REQ-028 then REQ-029), second load starting in the final-valid_o cycle -> both streams correct, 8 pulses each.
